// File: rtl/arb_pkg.sv
// Shared types and sizes for the round-robin decode arbiter.
// Also holds the combinational round-robin pick used by the top.
package arb_pkg;

   localparam int unsigned N_REQ  = 16;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned HOLD_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // First set request at or after ptr+1, wrapping; the smallest offset wins.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                     input logic [IDX_W-1:0] ptr);
      pick_t            p;
      logic [IDX_W-1:0] cand;
      p = '0;
      for (int off = N_REQ; off >= 1; off--) begin
         cand = IDX_W'(32'(ptr) + 32'(off));
         if (req[cand]) begin
            p.found = 1'b1;
            p.idx   = cand;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_decode_arbiter_dec.sv
// 4-to-16 gate-level decoder: one AND of true/complement address literals per output.
module rr_decode_arbiter_dec
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] a,
   output logic [N_REQ-1:0] y
);

   logic [IDX_W-1:0] an;

   assign an = ~a;

   for (genvar i = 0; i < int'(N_REQ); i++) begin : g_dec
      localparam logic [IDX_W-1:0] SEL = IDX_W'(i);
      logic [IDX_W-1:0] lit;
      assign lit = (SEL & a) | (~SEL & an);
      and u_and (y[i], lit[3], lit[2], lit[1], lit[0]);
   end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 16 requesters with a hold limit, a one-cycle dead gap
// between holders, and a one-hot grant decoded from the registered holder index.
module rr_decode_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 64
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             release_i,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic [N_REQ-1:0] grant,
   output logic             timeout_o
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  idx_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              valid_d;
   logic              timeout_d;
   logic              holder_done;
   logic              hold_hit;
   pick_t             pick;
   logic [N_REQ-1:0]  dec;

   // Next-state and next-output logic; defaults keep everything stable.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      idx_d       = grant_idx;
      hold_d      = hold_q;
      valid_d     = 1'b0;
      timeout_d   = 1'b0;
      pick        = rr_pick(req, ptr_q);
      holder_done = release_i | ~req[grant_idx];
      hold_hit    = (hold_q == HOLD_LAST);

      case (state_q)
         IDLE: begin
            if (pick.found) begin
               state_d = GRANT;
               ptr_d   = pick.idx;
               idx_d   = pick.idx;
               hold_d  = '0;
               valid_d = 1'b1;
            end
         end
         GRANT: begin
            if (hold_q != '1)
               hold_d = HOLD_W'(hold_q + 1'b1);
            // A release or dropped request takes priority over the hold limit.
            if (holder_done || hold_hit) begin
               state_d   = GAP;
               timeout_d = ~holder_done;
            end else begin
               valid_d = 1'b1;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '1;
         hold_q      <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         grant_idx   <= idx_d;
         grant_valid <= valid_d;
         timeout_o   <= timeout_d;
      end
   end

   rr_decode_arbiter_dec u_dec (
      .a (grant_idx),
      .y (dec)
   );

   assign grant = dec & {N_REQ{grant_valid}};

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: cycle model of the arbitration rules checked every
// cycle, plus directed scenarios with literal expectations.
module tb_rr_decode_arbiter;

   localparam int HOLD = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req;
   logic        release_i;
   logic [3:0]  grant_idx;
   logic        grant_valid;
   logic [15:0] grant;
   logic        timeout_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rr_decode_arbiter #(.MAX_HOLD(HOLD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .release_i   (release_i),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .grant       (grant),
      .timeout_o   (timeout_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_next(input logic [15:0] r, input int last);
      for (int k = 1; k <= 16; k++)
         if (r[(last + k) % 16]) return (last + k) % 16;
      return -1;
   endfunction

   // Model: who holds the bus, for how many cycles, and whether a dead gap is pending.
   int m_holder = -1;
   int m_held   = 0;
   int m_last   = 15;
   bit m_dead   = 1'b0;
   bit m_to     = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_holder = -1;
         m_held   = 0;
         m_last   = 15;
         m_dead   = 1'b0;
         m_to     = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_holder >= 0) begin
            if (release_i || !req[m_holder]) begin
               m_holder = -1;
               m_dead   = 1'b1;
            end else if (m_held + 1 == HOLD) begin
               m_holder = -1;
               m_dead   = 1'b1;
               m_to     = 1'b1;
            end else begin
               m_held = m_held + 1;
            end
         end else if (m_dead) begin
            m_dead = 1'b0;
         end else if (req != 16'h0) begin
            m_holder = rr_next(req, m_last);
            m_last   = m_holder;
            m_held   = 0;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("model valid", 32'(grant_valid), 32'(m_holder >= 0));
         chk("model grant", 32'(grant), (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
         chk("model timeout", 32'(timeout_o), 32'(m_to));
         if (m_holder >= 0)
            chk("model idx", 32'(grant_idx), 32'(m_holder));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wait_grant(input string name, input int exp_idx);
      int n = 0;
      while (!grant_valid && n < 40) begin
         cyc();
         n++;
      end
      chk({name, " valid"}, 32'(grant_valid), 32'd1);
      chk({name, " idx"}, 32'(grant_idx), 32'(exp_idx));
   endtask

   // Called on the first grant cycle; holds for 'cycles' grant cycles, ends in the gap.
   task automatic release_after(input int cycles);
      repeat (cycles - 1) cyc();
      release_i = 1'b1;
      cyc();
      release_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_valid;
      rst_n     = 1'b0;
      req       = 16'h0;
      release_i = 1'b0;
      repeat (3) cyc();
      chk("reset valid", 32'(grant_valid), 32'd0);
      chk("reset grant", 32'(grant), 32'd0);
      chk("reset idx", 32'(grant_idx), 32'd0);
      chk("reset timeout", 32'(timeout_o), 32'd0);

      // First arbitration after reset goes to requester 0.
      req   = 16'hFFFF;
      rst_n = 1'b1;
      cyc();
      chk("first grant", 32'(grant), 32'h0001);
      chk("first idx", 32'(grant_idx), 32'd0);

      // Full rotation with a dead cycle after each release.
      for (int k = 0; k <= 16; k++) begin
         wait_grant("rotation", k % 16);
         release_after(3);
         chk("rotation gap", 32'(grant_valid), 32'd0);
      end

      // Wrap from ptr 13 and skip to the next set bit.
      req = 16'h2000;
      wait_grant("ptr13", 13);
      req = 16'h0009;
      release_after(1);
      wait_grant("wrap", 0);
      release_after(1);
      wait_grant("skip", 3);
      release_after(1);
      wait_grant("wrap again", 0);

      // Hold limit reached with no release.
      req = 16'h0010;
      release_after(1);
      wait_grant("timeout grant", 4);
      n_valid = 0;
      while (grant_valid && n_valid < 20) begin
         n_valid++;
         cyc();
      end
      chk("timeout hold cycles", 32'(n_valid), 32'd8);
      chk("timeout pulse", 32'(timeout_o), 32'd1);
      chk("timeout gap grant", 32'(grant), 32'd0);
      cyc();
      chk("timeout pulse width", 32'(timeout_o), 32'd0);
      wait_grant("timeout regrant", 4);

      // Release coincides with the hold limit.
      repeat (7) cyc();
      chk("limit cycle valid", 32'(grant_valid), 32'd1);
      release_i = 1'b1;
      cyc();
      release_i = 1'b0;
      chk("release beats limit", 32'(timeout_o), 32'd0);
      chk("release beats limit gap", 32'(grant_valid), 32'd0);

      // Asynchronous reset in the middle of a grant.
      wait_grant("pre-reset", 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async grant", 32'(grant), 32'd0);
      chk("async valid", 32'(grant_valid), 32'd0);
      chk("async idx", 32'(grant_idx), 32'd0);
      chk("async timeout", 32'(timeout_o), 32'd0);
      req = 16'h8001;
      cyc();
      rst_n = 1'b1;
      wait_grant("post-reset", 0);
      release_after(1);
      wait_grant("post-reset next", 15);
      release_after(1);

      // A holder still requesting yields to the other requester first.
      req = 16'h0030;
      wait_grant("share a", 4);
      release_after(2);
      wait_grant("share b", 5);
      release_after(2);
      wait_grant("share a again", 4);
      req = 16'h0000;
      repeat (4) cyc();
      chk("idle after drop", 32'(grant_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
